// File: rtl/tube_name_scroller_pkg.sv
// Shared character codes and seven-segment patterns for the tube name scroller.
// Segment bit order is {a,b,c,d,e,f,g,dp}, active-high.
package tube_name_scroller_pkg;

    typedef logic [5:0] char_t;
    typedef logic [7:0] seg_t;

    typedef enum logic [5:0] {
        CHAR_0, CHAR_1, CHAR_2, CHAR_3, CHAR_4,
        CHAR_5, CHAR_6, CHAR_7, CHAR_8, CHAR_9,
        CHAR_A, CHAR_B, CHAR_C, CHAR_D, CHAR_E, CHAR_F, CHAR_G,
        CHAR_H, CHAR_I, CHAR_J, CHAR_K, CHAR_L, CHAR_M, CHAR_N,
        CHAR_O, CHAR_P, CHAR_Q, CHAR_R, CHAR_S, CHAR_T, CHAR_U,
        CHAR_V, CHAR_W, CHAR_X, CHAR_Y, CHAR_Z,
        CHAR_BLANK = 6'd63
    } char_code_e;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned RING_LEN   = 16;

    localparam seg_t SEG_0     = 8'b1111_1100;
    localparam seg_t SEG_1     = 8'b0110_0000;
    localparam seg_t SEG_2     = 8'b1101_1010;
    localparam seg_t SEG_3     = 8'b1111_0010;
    localparam seg_t SEG_4     = 8'b0110_0110;
    localparam seg_t SEG_5     = 8'b1011_0110;
    localparam seg_t SEG_6     = 8'b1011_1110;
    localparam seg_t SEG_7     = 8'b1110_0000;
    localparam seg_t SEG_8     = 8'b1111_1110;
    localparam seg_t SEG_9     = 8'b1111_0110;
    localparam seg_t SEG_A     = 8'b1110_1110;
    localparam seg_t SEG_B     = 8'b0011_1110;
    localparam seg_t SEG_C     = 8'b1001_1100;
    localparam seg_t SEG_D     = 8'b0111_1010;
    localparam seg_t SEG_E     = 8'b1001_1110;
    localparam seg_t SEG_F     = 8'b1000_1110;
    localparam seg_t SEG_G     = 8'b1011_1100;
    localparam seg_t SEG_H     = 8'b0110_1110;
    localparam seg_t SEG_I     = 8'b0000_1100;
    localparam seg_t SEG_J     = 8'b0111_1000;
    localparam seg_t SEG_K     = 8'b1010_1110;
    localparam seg_t SEG_L     = 8'b0001_1100;
    localparam seg_t SEG_M     = 8'b1010_1000;
    localparam seg_t SEG_N     = 8'b0010_1010;
    localparam seg_t SEG_O     = 8'b0011_1010;
    localparam seg_t SEG_P     = 8'b1100_1110;
    localparam seg_t SEG_Q     = 8'b1110_0110;
    localparam seg_t SEG_R     = 8'b0000_1010;
    localparam seg_t SEG_S     = 8'b1011_0110;
    localparam seg_t SEG_T     = 8'b0001_1110;
    localparam seg_t SEG_U     = 8'b0111_1100;
    localparam seg_t SEG_V     = 8'b0011_1000;
    localparam seg_t SEG_W     = 8'b0101_0100;
    localparam seg_t SEG_X     = 8'b0110_1110;
    localparam seg_t SEG_Y     = 8'b0111_0110;
    localparam seg_t SEG_Z     = 8'b1101_1010;
    localparam seg_t SEG_BLANK = 8'b0000_0000;

endpackage

// File: rtl/tube_name_scroller_char_decoder.sv
// Combinational character-code to seven-segment pattern decoder.
// Blank and every unassigned code light no segments.
module tube_char_decoder
    import tube_name_scroller_pkg::*;
(
    input  logic [5:0] i_code,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            CHAR_0:  o_seg = SEG_0;
            CHAR_1:  o_seg = SEG_1;
            CHAR_2:  o_seg = SEG_2;
            CHAR_3:  o_seg = SEG_3;
            CHAR_4:  o_seg = SEG_4;
            CHAR_5:  o_seg = SEG_5;
            CHAR_6:  o_seg = SEG_6;
            CHAR_7:  o_seg = SEG_7;
            CHAR_8:  o_seg = SEG_8;
            CHAR_9:  o_seg = SEG_9;
            CHAR_A:  o_seg = SEG_A;
            CHAR_B:  o_seg = SEG_B;
            CHAR_C:  o_seg = SEG_C;
            CHAR_D:  o_seg = SEG_D;
            CHAR_E:  o_seg = SEG_E;
            CHAR_F:  o_seg = SEG_F;
            CHAR_G:  o_seg = SEG_G;
            CHAR_H:  o_seg = SEG_H;
            CHAR_I:  o_seg = SEG_I;
            CHAR_J:  o_seg = SEG_J;
            CHAR_K:  o_seg = SEG_K;
            CHAR_L:  o_seg = SEG_L;
            CHAR_M:  o_seg = SEG_M;
            CHAR_N:  o_seg = SEG_N;
            CHAR_O:  o_seg = SEG_O;
            CHAR_P:  o_seg = SEG_P;
            CHAR_Q:  o_seg = SEG_Q;
            CHAR_R:  o_seg = SEG_R;
            CHAR_S:  o_seg = SEG_S;
            CHAR_T:  o_seg = SEG_T;
            CHAR_U:  o_seg = SEG_U;
            CHAR_V:  o_seg = SEG_V;
            CHAR_W:  o_seg = SEG_W;
            CHAR_X:  o_seg = SEG_X;
            CHAR_Y:  o_seg = SEG_Y;
            CHAR_Z:  o_seg = SEG_Z;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tube_name_scroller.sv
// 8-digit multiplexed seven-segment driver that shows a latched song name,
// optionally scrolling it right-to-left through a 16-position ring.
module tube_name_scroller
    import tube_name_scroller_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned SCROLL_DIV = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:47] name,
    input  logic        load,
    input  logic        scroll_en,
    output logic [7:0]  seg_out,
    output logic [7:0]  an,
    output logic        lap_done
);

    localparam int unsigned PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit;
    logic [SW-1:0] r_scroll;
    logic [3:0]    r_offset;
    char_t         r_name [NUM_DIGITS];
    logic [7:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_lap;

    logic          w_scan_tick;
    logic          w_scroll_term;
    logic [3:0]    w_ring_idx;
    char_t         w_char;
    seg_t          w_seg;

    assign w_scan_tick   = (r_presc == PW'(SCAN_DIV - 1));
    assign w_scroll_term = (r_scroll == SW'(SCROLL_DIV - 1));

    // Ring positions 8..15 are implicit blanks, giving the gap between laps.
    assign w_ring_idx = r_offset + {1'b0, r_digit};
    assign w_char     = w_ring_idx[3] ? CHAR_BLANK : r_name[w_ring_idx[2:0]];

    tube_char_decoder u_decoder (
        .i_code (w_char),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_scan_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // The digit being shown is the pre-increment index, so the first tick lights digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
            r_an    <= '0;
            r_seg   <= '0;
        end else if (w_scan_tick) begin
            r_digit <= r_digit + 3'd1;
            r_an    <= 8'h80 >> r_digit;
            r_seg   <= w_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_name[i] <= CHAR_BLANK;
            end
        end else if (load) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_name[i] <= name[6*i +: 6];
            end
        end
    end

    // load outranks scroll_en, which outranks a scroll step; only a real step can flag a lap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scroll <= '0;
            r_offset <= '0;
            r_lap    <= 1'b0;
        end else begin
            r_lap <= 1'b0;
            if (load || !scroll_en) begin
                r_scroll <= '0;
                r_offset <= '0;
            end else if (w_scan_tick) begin
                if (w_scroll_term) begin
                    r_scroll <= '0;
                    r_offset <= r_offset + 4'd1;
                    r_lap    <= (r_offset == 4'hF);
                end else begin
                    r_scroll <= r_scroll + SW'(1);
                end
            end
        end
    end

    assign seg_out  = r_seg;
    assign an       = r_an;
    assign lap_done = r_lap;

endmodule
